// File: rtl/nios2_pio_in_irq.sv
// Avalon-MM input PIO with synchroniser, optional debounce filter,
// sticky edge capture and a masked level interrupt.
module nios2_pio_in_irq #(
  parameter int               WIDTH           = 2,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter int               EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] ec_clear;
  logic [31:0]      rd_mux;
  logic             wr_en;

  // Metastability chain; the last stage is the first usable copy of the pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RESET_VALUE;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    assign filt = sync_s;
  end else begin : g_debounce
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // Accept a new level only after it has differed from the filtered
    // value for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        filt_q <= RESET_VALUE;
        for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
      end else begin
        for (int b = 0; b < WIDTH; b++) begin
          if (sync_s[b] != filt_q[b]) begin
            if (cnt[b] == CNT_LAST) begin
              filt_q[b] <= sync_s[b];
              cnt[b]    <= '0;
            end else begin
              cnt[b] <= cnt[b] + CNT_W'(1);
            end
          end else begin
            cnt[b] <= '0;
          end
        end
      end
    end

    assign filt = filt_q;
  end

  // Previous filtered level; reset with the filter so release makes no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= RESET_VALUE;
    else          prev <= filt;
  end

  // Edge qualifier chosen at build time.
  always_comb begin
    edge_det = '0;
    case (EDGE_MODE)
      0:       edge_det = filt & ~prev;
      1:       edge_det = ~filt & prev;
      default: edge_det = filt ^ prev;
    endcase
  end

  assign wr_en = chipselect & ~write_n;

  // Writedata bits above WIDTH have no destination.
  if (WIDTH < 32) begin : g_unused_wd
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              irqmask <= '0;
    else if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
  end

  // Write-one-to-clear mask for the capture register.
  always_comb begin
    ec_clear = '0;
    if (wr_en && address == ADDR_EDGECAP) ec_clear = writedata[WIDTH-1:0];
  end

  // Sticky capture; a new edge in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecapture <= '0;
    else          edgecapture <= (edgecapture & ~ec_clear) | edge_det;
  end

  // Zero-extended register mux; reserved and unmapped bits read 0.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = filt;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
      default:      rd_mux = '0;
    endcase
  end

  // Read data registered every clock regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  // Registered level interrupt from any unmasked captured edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(edgecapture & irqmask);
  end

endmodule
